// File: rtl/dawn_mem_pkg.sv
// Shared definitions for the Y86-64 data-memory responder: FSM encoding,
// word geometry and the status code that rsp_error_o stands for.
package dawn_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 8;

  // rsp_error_o is reported by the memory stage as stat = SADR.
  localparam logic [3:0] STAT_AOK  = 4'h1;
  localparam logic [3:0] STAT_SADR = 4'h3;
  localparam logic       RSP_ERROR = 1'b1;

  // Sum in 65 bits so addresses close to 2^64 are flagged instead of wrapping.
  function automatic logic out_of_range(input logic [63:0] addr, input int unsigned depth);
    return ({1'b0, addr} + 65'(WORD_BYTES)) > 65'(depth);
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with one synchronous 8-byte little-endian port.
// No reset and no range check; the caller guarantees addr..addr+7 is in range.
module mem_byte_array
  import dawn_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_BYTES)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [63:0]       wdata_i,
  output logic [63:0]       rdata_o
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < WORD_BYTES; i++)
          mem[addr_i + ADDR_W'(i)] <= wdata_i[8*i +: 8];
      end else begin
        for (int i = 0; i < WORD_BYTES; i++)
          rdata_o[8*i +: 8] <= mem[addr_i + ADDR_W'(i)];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory slave for the pipeline's memory stage:
// one request in flight, valid/ready response with out-of-range error.
module dmem_responder
  import dawn_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        busy_o
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_e      state, state_nxt;
  logic [CW-1:0] cnt;
  logic        hold_we;
  logic [63:0] hold_addr, hold_wdata;
  logic        accept, complete;
  logic        cmp_we, cmp_err;
  logic [63:0] cmp_addr, cmp_wdata;
  logic        rd_sel;
  logic [63:0] mem_rdata;

  assign accept   = (state == IDLE) && req_valid_i;
  assign complete = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == CW'(1)));

  // With LATENCY = 1 completion coincides with the accept edge, so the live
  // request is used; otherwise the held copy is.
  assign cmp_we    = (state == IDLE) ? req_we_i    : hold_we;
  assign cmp_addr  = (state == IDLE) ? req_addr_i  : hold_addr;
  assign cmp_wdata = (state == IDLE) ? req_wdata_i : hold_wdata;
  assign cmp_err   = out_of_range(cmp_addr, DEPTH_BYTES);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == CW'(1)) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE);
    rsp_valid_o = (state == RESP);
    busy_o      = (state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)            cnt <= '0;
    else if (accept)         cnt <= CW'(LATENCY - 1);
    else if (state == WAIT)  cnt <= cnt - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      hold_we    <= req_we_i;
      hold_addr  <= req_addr_i;
      hold_wdata <= req_wdata_i;
    end
  end

  // rd_sel gates the array's read register so stores, errors and reset show 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_error_o <= 1'b0;
      rd_sel      <= 1'b0;
    end else if (complete) begin
      rsp_error_o <= cmp_err;
      rd_sel      <= !cmp_we && !cmp_err;
    end
  end

  assign rsp_rdata_o = rd_sel ? mem_rdata : '0;

  mem_byte_array #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .ADDR_W      (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .en_i    (complete && !cmp_err),
    .we_i    (cmp_we),
    .addr_i  (cmp_addr[AW-1:0]),
    .wdata_i (cmp_wdata),
    .rdata_o (mem_rdata)
  );

endmodule
